// File: rtl/temp_request_gen.sv
// Heat/cool request generator: hysteresis classification, consecutive-sample
// confirmation and minimum dwell ahead of the heating/cooling controller.
module temp_request_gen #(
    parameter int W         = 10,
    parameter int HYST      = 4,
    parameter int CONFIRM   = 3,
    parameter int MIN_DWELL = 16
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         sample_valid,
    input  logic [W-1:0] target,
    input  logic [W-1:0] ambient,
    output logic         A,
    output logic         B
);

    localparam int CW = $clog2(CONFIRM + 1);
    localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

    localparam logic [CW-1:0]       CONFIRM_V = CW'(CONFIRM);
    localparam logic [DW-1:0]       DWELL_V   = DW'(MIN_DWELL);
    localparam logic signed [W:0]   HYST_P    = (W+1)'(HYST);
    localparam logic signed [W:0]   HYST_N    = -HYST_P;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_COLD = 2'd1,
        CLS_HOT  = 2'd2,
        CLS_EXIT = 2'd3
    } cls_t;

    typedef enum logic {
        DIR_COLD = 1'b0,
        DIR_HOT  = 1'b1
    } dir_t;

    state_t         state_q, state_d;
    dir_t           dir_q, dir_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic           a_q, a_d;
    logic           b_q, b_d;

    logic signed [W:0] diff;
    cls_t              cls;
    dir_t              sample_dir;
    logic              fire;
    logic [CW-1:0]     cnt_inc;

    assign diff       = $signed({1'b0, ambient}) - $signed({1'b0, target});
    assign sample_dir = (cls == CLS_HOT) ? DIR_HOT : DIR_COLD;
    assign fire       = (cnt_q == CONFIRM_V) && (dwell_q == '0);
    assign cnt_inc    = (cnt_q == CONFIRM_V) ? cnt_q : cnt_q + CW'(1);

    // Classification thresholds depend on which state we are trying to leave.
    always_comb begin
        cls = CLS_NONE;
        case (state_q)
            IDLE: begin
                if (diff < HYST_N) begin
                    cls = CLS_COLD;
                end else if (diff > HYST_P) begin
                    cls = CLS_HOT;
                end
            end
            HEAT: begin
                if (!diff[W]) begin
                    cls = CLS_EXIT;
                end
            end
            COOL: begin
                if (diff[W] || (diff == '0)) begin
                    cls = CLS_EXIT;
                end
            end
            default: cls = CLS_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = (dir_q == DIR_HOT) ? COOL : HEAT;
                end
            end
            HEAT, COOL: begin
                if (fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A sample arriving on the edge that changes state is dropped.
        if (state_d != state_q) begin
            cnt_d   = '0;
            dwell_d = DWELL_V;
        end else begin
            if (dwell_q != '0) begin
                dwell_d = dwell_q - DW'(1);
            end
            if (sample_valid) begin
                case (cls)
                    CLS_COLD, CLS_HOT: begin
                        if (sample_dir == dir_q) begin
                            cnt_d = cnt_inc;
                        end else begin
                            cnt_d = CW'(1);
                            dir_d = sample_dir;
                        end
                    end
                    CLS_EXIT: cnt_d = cnt_inc;
                    default:  cnt_d = '0;
                endcase
            end
        end

        a_d = (state_d == HEAT);
        b_d = (state_d == COOL);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_COLD;
            cnt_q   <= '0;
            dwell_q <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign A = a_q;
    assign B = b_q;

endmodule

// File: tb/tb_temp_request_gen.sv
// Bench for temp_request_gen: hand-built vector tables for the documented
// scenarios plus randomized runs against a run-length/edge-count reference model.
module tb_temp_request_gen;

    localparam int W         = 10;
    localparam int HYST      = 4;
    localparam int CONFIRM   = 3;
    localparam int MIN_DWELL = 16;

    localparam int ST_IDLE = 0;
    localparam int ST_HEAT = 1;
    localparam int ST_COOL = 2;

    logic         clock = 1'b0;
    logic         rst;
    logic         sample_valid;
    logic [W-1:0] target;
    logic [W-1:0] ambient;
    logic         a_out;
    logic         b_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    temp_request_gen #(
        .W(W), .HYST(HYST), .CONFIRM(CONFIRM), .MIN_DWELL(MIN_DWELL)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .sample_valid (sample_valid),
        .target       (target),
        .ambient      (ambient),
        .A            (a_out),
        .B            (b_out)
    );

    // Reference: confirmation is the run of identical qualifying classes since
    // the last clear; dwell is measured as edges since the last state change.
    int m_state;
    int m_run[$];
    int m_edge;
    int m_last;
    bit m_has_change;

    task automatic model_reset();
        m_state      = ST_IDLE;
        m_run.delete();
        m_edge       = 0;
        m_last       = 0;
        m_has_change = 0;
    endtask

    function automatic int classify(int st, int d);
        if (st == ST_IDLE) begin
            if (d < -HYST) return 1;
            if (d > HYST)  return 2;
            return 0;
        end
        if (st == ST_HEAT) return (d >= 0) ? 3 : 0;
        return (d <= 0) ? 3 : 0;
    endfunction

    task automatic model_edge();
        int  d;
        int  c;
        bit  dwell_ok;
        m_edge++;
        d        = int'(ambient) - int'(target);
        dwell_ok = !m_has_change || (m_edge >= m_last + MIN_DWELL + 1);
        if (m_run.size() >= CONFIRM && dwell_ok) begin
            if (m_state == ST_IDLE) m_state = (m_run[0] == 1) ? ST_HEAT : ST_COOL;
            else                    m_state = ST_IDLE;
            m_run.delete();
            m_last       = m_edge;
            m_has_change = 1;
        end else if (sample_valid) begin
            c = classify(m_state, d);
            if (c == 0) m_run.delete();
            else if (m_run.size() > 0 && m_run[0] != c) m_run = {c};
            else if (m_run.size() < CONFIRM) m_run.push_back(c);
        end
    endtask

    task automatic checkOutput(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0b, expected %0b", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(bit v, int t, int am);
        sample_valid = v;
        target       = W'(t);
        ambient      = W'(am);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        checkOutput($sformatf("model_A edge%0d", m_edge), a_out, m_state == ST_HEAT);
        checkOutput($sformatf("model_B edge%0d", m_edge), b_out, m_state == ST_COOL);
        checkOutput("exclusive_AB", a_out & b_out, 1'b0);
    endtask

    task automatic applyReset();
        @(negedge clock);
        rst = 1'b0;
        #1;
        checkOutput("reset_A", a_out, 1'b0);
        checkOutput("reset_B", b_out, 1'b0);
        @(negedge clock);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit do_reset;
        bit valid;
        int tgt;
        int amb;
        int cycles;
        bit exp_a;
        bit exp_b;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int diff;
        int len;
        int tgt;
        int amb;

        rst = 1'b0;
        applyStimulus(0, 0, 0);
        model_reset();
        #2;
        checkOutput("por_A", a_out, 1'b0);
        checkOutput("por_B", b_out, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b1;

        // Heat entry, dwell hold, band edges, cool entry, COOL->IDLE->HEAT.
        vecs.push_back('{0, 1, 200, 195,  3, 0, 0});
        vecs.push_back('{0, 0, 200, 200,  1, 1, 0});
        vecs.push_back('{0, 0, 200, 195,  1, 1, 0});
        vecs.push_back('{0, 1, 200, 200,  3, 1, 0});
        vecs.push_back('{0, 0, 200, 200, 12, 1, 0});
        vecs.push_back('{0, 0, 200, 200,  1, 0, 0});
        vecs.push_back('{0, 1, 200, 196, 10, 0, 0});
        vecs.push_back('{0, 1, 200, 204, 10, 0, 0});
        vecs.push_back('{0, 1, 200, 205,  3, 0, 0});
        vecs.push_back('{0, 1, 200, 205,  1, 0, 1});
        vecs.push_back('{0, 1, 200, 194, 16, 0, 1});
        vecs.push_back('{0, 1, 200, 194,  1, 0, 0});
        vecs.push_back('{0, 1, 200, 194, 16, 0, 0});
        vecs.push_back('{0, 1, 200, 194,  1, 1, 0});
        // Interrupted confirmation with idle gaps between samples.
        vecs.push_back('{1, 1, 200, 195,  2, 0, 0});
        vecs.push_back('{0, 1, 200, 197,  1, 0, 0});
        vecs.push_back('{0, 1, 200, 195,  1, 0, 0});
        vecs.push_back('{0, 0, 200, 195,  3, 0, 0});
        vecs.push_back('{0, 1, 200, 195,  1, 0, 0});
        vecs.push_back('{0, 0, 200, 195,  2, 0, 0});
        vecs.push_back('{0, 1, 200, 195,  1, 0, 0});
        vecs.push_back('{0, 0,   0,   0,  1, 1, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) applyReset();
            applyStimulus(vecs[i].valid, vecs[i].tgt, vecs[i].amb);
            for (int c = 0; c < vecs[i].cycles; c++) step();
            checkOutput($sformatf("vec%0d_A", i), a_out, vecs[i].exp_a);
            checkOutput($sformatf("vec%0d_B", i), b_out, vecs[i].exp_b);
            if (i == 13) begin
                #3;
                rst = 1'b0;
                #1;
                checkOutput("async_drop_A", a_out, 1'b0);
                checkOutput("async_drop_B", b_out, 1'b0);
                #2;
                rst = 1'b1;
                model_reset();
            end
        end

        // Randomized held-diff segments, occasional extremes and resets.
        for (int s = 0; s < 320; s++) begin
            if (s % 100 == 99) applyReset();
            diff = int'($urandom_range(0, 16)) - 8;
            len  = int'($urandom_range(1, 6));
            tgt  = int'($urandom_range(20, 1000));
            amb  = tgt + diff;
            if ($urandom_range(0, 15) == 0) begin
                tgt = ($urandom_range(0, 1) == 0) ? 0 : 1023;
                amb = 1023 - tgt;
            end
            for (int c = 0; c < len; c++) begin
                applyStimulus($urandom_range(0, 4) != 0, tgt, amb);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_request_gen.md
# temp_request_gen

Upstream request generator for the heating/cooling controller FSM. It accepts periodic temperature samples (target and ambient) and applies hysteresis, consecutive-sample confirmation and a minimum dwell time. From these it drives the controller's heat-request (A) and cool-request (B) inputs. Its outputs connect directly to the A and B inputs of the controller; A and B are never asserted together.

## Interface
Parameters:
- W, 10, temperature width, unsigned, 0.25 °C per LSB
- HYST, 4, hysteresis band in LSBs (HYST ≥ 0, < 2^(W-1))
- CONFIRM, 3, consecutive qualifying samples required to change state (≥ 1)
- MIN_DWELL, 16, clock cycles a state is held before any further change (≥ 0)

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- sample_valid  input  1  target/ambient valid this cycle; sample accepted every cycle it is 1 (no back-pressure)
- target  input  W  target temperature
- ambient  input  W  ambient temperature
- A  output  1  heat request, registered, 1 only in state HEAT
- B  output  1  cool request, registered, 1 only in state COOL

## Operation
- diff = ambient − target, computed as W+1-bit signed with both operands zero-extended; no overflow is possible.
- Sample class depends on the current state:
  - IDLE: diff < −HYST → COLD; diff > +HYST → HOT; otherwise NEUTRAL.
  - HEAT: diff ≥ 0 → EXIT, else STAY.
  - COOL: diff ≤ 0 → EXIT, else STAY.
- Confirmation counter cnt (width clog2(CONFIRM+1)) with direction bit dir; both update only on accepted samples:
  - Qualifying sample with the same class as dir → cnt increments, saturating at CONFIRM.
  - Qualifying sample with a different class → cnt = 1, dir = new class.
  - NEUTRAL or STAY sample → cnt = 0.
  - Cycles with sample_valid = 0 leave cnt unchanged.
- Dwell counter dwell (width clog2(MIN_DWELL+1)):
  - Loaded with MIN_DWELL on every state-change edge.
  - Otherwise decrements each cycle while nonzero.
- State machine: IDLE, HEAT, COOL. A transition is taken on any edge where cnt == CONFIRM and dwell == 0; no sample is needed on that edge.
  - IDLE → HEAT when dir = COLD; IDLE → COOL when dir = HOT.
  - HEAT → IDLE and COOL → IDLE on EXIT.
  - HEAT ↔ COOL directly is illegal; the path always goes through IDLE.
- On a state-change edge, cnt clears to 0. A sample presented on that same edge is discarded.
- An illegal state encoding recovers to IDLE on the next edge, with A = B = 0.

## Timing
- Reset (rst = 0): state = IDLE, A = 0, B = 0, cnt = 0, dir = COLD, dwell = 0. This takes effect immediately, without waiting for a clock edge.
- After reset release, the first transition is not dwell-blocked.
- Latency: if the CONFIRM-th qualifying sample is accepted at edge k with dwell == 0, A/B change after edge k+1.
- Dwell: a state entered at edge t0 holds through edge t0+MIN_DWELL. The earliest next change is edge t0+MIN_DWELL+1.
- Samples accepted during dwell still count toward cnt, which saturates at CONFIRM.
- Reset asserted mid-dwell or mid-count drops A/B asynchronously and clears all counters.

## Test plan
- HEAT via rst pulse: reach HEAT, then drive rst = 0 between clock edges → A falls before the next edge; B stays 0.
- Heat entry: target = 200, ambient = 195 (diff −5), sample_valid = 1 for 3 cycles → A = 1 after the edge following the 3rd sample; B = 0 throughout.
- Band edge: target = 200, ambient = 196 (diff −4 = −HYST) for 10 samples → A = B = 0. Repeat with ambient = 204 → still idle. With ambient = 205 ×3 → B = 1.
- Interrupted confirmation: diff sequence −5, −5, −3, −5, −5 → no request. Sixth sample −5 → A = 1. Idle cycles (sample_valid = 0) inserted between samples do not reset the count.
- Dwell hold: enter HEAT at t0, then diff = 0 on 3 samples at t0+2..t0+4 → A stays 1 until edge t0+17 and falls after it.
- Mutual exclusion: in COOL, apply diff = −6 continuously → COOL → IDLE (B = 0), dwell 16 cycles, then IDLE → HEAT. A and B are never 1 in the same cycle.
